mem_arbiter: RTL and testbench

Request arbiter and sequencer for the shared byte-serial memory controller. Accepts transactions from the instruction fetch unit and the load/store buffer, and grants exactly one at a time to the controller. Drops speculative work (loads, fetches) on pipeline clear, and guarantees committed stores complete. Uses bounded-starvation priority so instruction fetch always makes progress under heavy load/store traffic.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer between instruction fetch and load/store for the shared byte-serial
// memory controller: one transaction in flight, starvation-bounded priority, flush kill.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        clear,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [63:0] if_data,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [2:0]  ls_len,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        mc_sig,
   output logic        mc_wr,
   output logic [3:0]  mc_len,
   output logic [31:0] mc_addr,
   output logic [31:0] mc_wdata,
   input  logic        mc_done,
   input  logic [63:0] mc_rdata,
   output logic [1:0]  dbg_state,
   output logic [3:0]  dbg_starve_cnt
);

   // Handshake: a requester raises req with a stable payload and holds it until its
   // one-cycle done pulse (or until it flushes with clear); the payload is latched at
   // grant, so req is not re-examined afterwards.
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

   localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

   state_t     state;
   kind_t      kind;
   logic [3:0] starve_cnt;
   logic       mc_sig_q;
   logic       if_done_q;
   logic       ls_done_q;
   logic       kill;
   logic       ls_elig;
   logic       if_elig;
   logic       pick_if;
   logic       pick_ls;

   function automatic logic [31:0] len_mask(input logic [3:0] len);
      case (len)
         4'd1:    len_mask = 32'h0000_00ff;
         4'd2:    len_mask = 32'h0000_ffff;
         4'd3:    len_mask = 32'h00ff_ffff;
         default: len_mask = 32'hffff_ffff;
      endcase
   endfunction

   assign kill    = rdy && clear && (kind != K_STORE);
   assign ls_elig = ls_req && (ls_wr || !clear);
   assign if_elig = if_req && !clear;
   assign pick_if = if_elig && (!ls_elig || starve_cnt == LIMIT);
   assign pick_ls = ls_elig && !pick_if;

   // A flush suppresses the start/done strobe of speculative work in the same cycle.
   assign mc_sig  = mc_sig_q && !kill;
   assign if_done = if_done_q && !kill;
   assign ls_done = ls_done_q && !kill;

   assign dbg_state      = state;
   assign dbg_starve_cnt = starve_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         kind       <= K_FETCH;
         starve_cnt <= 4'd0;
         mc_sig_q   <= 1'b0;
         if_done_q  <= 1'b0;
         ls_done_q  <= 1'b0;
         mc_wr      <= 1'b0;
         mc_len     <= 4'd0;
         mc_addr    <= 32'd0;
         mc_wdata   <= 32'd0;
         if_data    <= 64'd0;
         ls_rdata   <= 32'd0;
      end else if (rdy) begin
         case (state)
            IDLE: begin
               if (pick_if) begin
                  state      <= ISSUE;
                  kind       <= K_FETCH;
                  mc_sig_q   <= 1'b1;
                  mc_wr      <= 1'b0;
                  mc_len     <= 4'd8;
                  mc_addr    <= if_addr;
                  starve_cnt <= 4'd0;
               end else if (pick_ls) begin
                  state    <= ISSUE;
                  kind     <= ls_wr ? K_STORE : K_LOAD;
                  mc_sig_q <= 1'b1;
                  mc_wr    <= ls_wr;
                  mc_len   <= {1'b0, ls_len};
                  mc_addr  <= ls_addr;
                  mc_wdata <= ls_wdata;
                  if (!if_req)
                     starve_cnt <= 4'd0;
                  else if (starve_cnt < LIMIT)
                     starve_cnt <= starve_cnt + 4'd1;
               end else if (!if_req) begin
                  starve_cnt <= 4'd0;
               end
            end
            ISSUE: begin
               mc_sig_q <= 1'b0;
               state    <= kill ? IDLE : WAIT;
            end
            WAIT: begin
               if (kill) begin
                  state <= IDLE;
               end else if (mc_done) begin
                  state <= RESP;
                  if (kind == K_FETCH) begin
                     if_data   <= mc_rdata;
                     if_done_q <= 1'b1;
                  end else begin
                     if (kind == K_LOAD)
                        ls_rdata <= mc_rdata[31:0] & len_mask(mc_len);
                     ls_done_q <= 1'b1;
                  end
               end
            end
            RESP: begin
               if_done_q <= 1'b0;
               ls_done_q <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a queue-fed memory-controller model, a scoreboard
// monitor on mc_sig / if_done / ls_done, and timing/state spot checks.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        rdy;
   logic        clear;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [63:0] if_data;
   logic        ls_req;
   logic        ls_wr;
   logic [2:0]  ls_len;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic        mc_sig;
   logic        mc_wr;
   logic [3:0]  mc_len;
   logic [31:0] mc_addr;
   logic [31:0] mc_wdata;
   logic        mc_done;
   logic [63:0] mc_rdata;
   logic [1:0]  dbg_state;
   logic [3:0]  dbg_starve_cnt;

   logic        mc_auto;
   int          mc_lat;
   logic        auto_done;
   logic [63:0] auto_rdata;
   logic        man_done;
   logic [63:0] man_rdata;

   int checks;
   int failures;

   logic [68:0] exp_mc_q[$];
   logic [63:0] exp_if_q[$];
   logic [32:0] exp_ls_q[$];
   logic [63:0] rsp_q[$];

   assign mc_done  = mc_auto ? auto_done  : man_done;
   assign mc_rdata = mc_auto ? auto_rdata : man_rdata;

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rdy            (rdy),
      .clear          (clear),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .if_done        (if_done),
      .if_data        (if_data),
      .ls_req         (ls_req),
      .ls_wr          (ls_wr),
      .ls_len         (ls_len),
      .ls_addr        (ls_addr),
      .ls_wdata       (ls_wdata),
      .ls_done        (ls_done),
      .ls_rdata       (ls_rdata),
      .mc_sig         (mc_sig),
      .mc_wr          (mc_wr),
      .mc_len         (mc_len),
      .mc_addr        (mc_addr),
      .mc_wdata       (mc_wdata),
      .mc_done        (mc_done),
      .mc_rdata       (mc_rdata),
      .dbg_state      (dbg_state),
      .dbg_starve_cnt (dbg_starve_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_mc(input logic wr, input logic [3:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata);
      exp_mc_q.push_back({wr, len, addr, wdata});
   endtask

   // sel: 0 mc_sig, 1 if_done, 2 ls_done; returns at the negedge the signal is seen
   task automatic wait_out(input int sel, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((sel == 0 && mc_sig) || (sel == 1 && if_done) || (sel == 2 && ls_done)) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL timeout_%s actual=no_event required=event", name);
      end
   endtask

   // memory controller model: answers each start from rsp_q after mc_lat cycles
   initial begin
      logic rsp_prev;
      logic [63:0] d;
      rsp_prev   = 1'b0;
      auto_done  = 1'b0;
      auto_rdata = 64'd0;
      forever begin
         @(negedge clk);
         #1;
         if (mc_auto && mc_sig && !rsp_prev) begin
            if (rsp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_underflow actual=empty required=data");
               d = 64'd0;
            end else begin
               d = rsp_q.pop_front();
            end
            repeat (mc_lat - 1) @(negedge clk);
            #1;
            auto_rdata = d;
            auto_done  = 1'b1;
            @(negedge clk);
            #1;
            auto_done = 1'b0;
            rsp_prev  = 1'b0;
         end else begin
            rsp_prev = mc_sig;
         end
      end
   end

   // scoreboard monitor
   initial begin
      logic sig_prev, if_prev, ls_prev, mcd_prev;
      logic [68:0] em;
      logic [32:0] el;
      sig_prev = 1'b0;
      if_prev  = 1'b0;
      ls_prev  = 1'b0;
      mcd_prev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (mc_sig && !sig_prev) begin
               if (exp_mc_q.size() == 0) begin
                  check("mc_unexpected", 64'(mc_sig), 64'd0);
               end else begin
                  em = exp_mc_q.pop_front();
                  check("mc_wr", 64'(mc_wr), 64'(em[68]));
                  check("mc_len", 64'(mc_len), 64'(em[67:64]));
                  check("mc_addr", 64'(mc_addr), 64'(em[63:32]));
                  if (em[68]) check("mc_wdata", 64'(mc_wdata), 64'(em[31:0]));
               end
            end
            if (if_done && !if_prev) begin
               check("if_done_latency", 64'(mcd_prev), 64'd1);
               if (exp_if_q.size() == 0) check("if_unexpected", 64'(if_done), 64'd0);
               else check("if_data", if_data, exp_if_q.pop_front());
            end
            if (ls_done && !ls_prev) begin
               check("ls_done_latency", 64'(mcd_prev), 64'd1);
               if (exp_ls_q.size() == 0) begin
                  check("ls_unexpected", 64'(ls_done), 64'd0);
               end else begin
                  el = exp_ls_q.pop_front();
                  if (el[32]) check("ls_rdata", 64'(ls_rdata), 64'(el[31:0]));
               end
            end
         end
         sig_prev = mc_sig;
         if_prev  = if_done;
         ls_prev  = ls_done;
         mcd_prev = mc_done;
      end
   end

   // stimulus
   initial begin
      logic [2:0]  st_len [5];
      logic [31:0] st_dat [5];
      logic [31:0] st_exp [5];
      st_len = '{3'd4, 3'd1, 3'd2, 3'd4, 3'd1};
      st_dat = '{32'h1122_3344, 32'h5566_7788, 32'h99aa_bbcc, 32'hddee_ff00, 32'h0f1e_2d3c};
      st_exp = '{32'h1122_3344, 32'h0000_0088, 32'h0000_bbcc, 32'hddee_ff00, 32'h0000_003c};

      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      rdy = 1'b1;
      clear = 1'b0;
      if_req = 1'b0;
      if_addr = 32'd0;
      ls_req = 1'b0;
      ls_wr = 1'b0;
      ls_len = 3'd0;
      ls_addr = 32'd0;
      ls_wdata = 32'd0;
      mc_auto = 1'b1;
      mc_lat = 4;
      man_done = 1'b0;
      man_rdata = 64'd0;

      repeat (3) @(negedge clk);
      check("rst_state", 64'(dbg_state), 64'd0);
      check("rst_starve", 64'(dbg_starve_cnt), 64'd0);
      check("rst_mc_sig", 64'(mc_sig), 64'd0);
      check("rst_mc_addr", 64'(mc_addr), 64'd0);
      check("rst_if_done", 64'(if_done), 64'd0);
      check("rst_ls_done", 64'(ls_done), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single fetch
      mc_lat = 8;
      push_mc(1'b0, 4'd8, 32'h0000_1000, 32'd0);
      rsp_q.push_back(64'h0123_4567_89ab_cdef);
      exp_if_q.push_back(64'h0123_4567_89ab_cdef);
      if_addr = 32'h0000_1000;
      if_req = 1'b1;
      @(negedge clk);
      check("grant_latency", 64'(mc_sig), 64'd1);
      wait_out(1, "fetch");
      if_req = 1'b0;
      @(negedge clk);
      check("fetch_idle", 64'(dbg_state), 64'd0);

      // simultaneous requests: load first, fetch at IDLE after its RESP
      mc_lat = 4;
      push_mc(1'b0, 4'd2, 32'h0000_0020, 32'd0);
      push_mc(1'b0, 4'd8, 32'h0000_2000, 32'd0);
      rsp_q.push_back(64'hffff_ffff_ffff_beef);
      rsp_q.push_back(64'h1111_2222_3333_4444);
      exp_ls_q.push_back({1'b1, 32'h0000_beef});
      exp_if_q.push_back(64'h1111_2222_3333_4444);
      fork
         begin
            if_addr = 32'h0000_2000;
            if_req = 1'b1;
            wait_out(1, "sim_fetch");
            if_req = 1'b0;
         end
         begin
            ls_wr = 1'b0;
            ls_len = 3'd2;
            ls_addr = 32'h0000_0020;
            ls_req = 1'b1;
            wait_out(2, "sim_load");
            ls_req = 1'b0;
            @(negedge clk);
            check("sim_idle_after_resp", 64'(dbg_state), 64'd0);
            @(negedge clk);
            check("sim_fetch_grant", 64'(mc_sig), 64'd1);
         end
      join
      @(negedge clk);
      check("sim_starve_zero", 64'(dbg_starve_cnt), 64'd0);

      // starvation: four load grants, then the fetch is forced
      for (int i = 0; i < 5; i++) begin
         push_mc(1'b0, {1'b0, st_len[i]}, 32'h0000_0100 + 32'(4 * i), 32'd0);
         rsp_q.push_back({32'hffff_ffff, st_dat[i]});
         exp_ls_q.push_back({1'b1, st_exp[i]});
         if (i == 3) begin
            push_mc(1'b0, 4'd8, 32'h0000_3000, 32'd0);
            rsp_q.push_back(64'h0a0b_0c0d_0e0f_1011);
            exp_if_q.push_back(64'h0a0b_0c0d_0e0f_1011);
         end
      end
      fork
         begin
            if_addr = 32'h0000_3000;
            if_req = 1'b1;
            wait_out(1, "starve_fetch");
            if_req = 1'b0;
            check("starve_cnt_after_fetch", 64'(dbg_starve_cnt), 64'd0);
         end
         begin
            for (int i = 0; i < 5; i++) begin
               ls_wr = 1'b0;
               ls_len = st_len[i];
               ls_addr = 32'h0000_0100 + 32'(4 * i);
               ls_req = 1'b1;
               wait_out(2, "starve_load");
               if (i == 3) check("starve_cnt_limit", 64'(dbg_starve_cnt), 64'd4);
            end
            ls_req = 1'b0;
         end
      join
      repeat (2) @(negedge clk);

      // clear during load WAIT, pending fetch held off while clear is high
      mc_auto = 1'b0;
      push_mc(1'b0, 4'd4, 32'h0000_0040, 32'd0);
      ls_wr = 1'b0;
      ls_len = 3'd4;
      ls_addr = 32'h0000_0040;
      ls_req = 1'b1;
      wait_out(0, "clr_load_issue");
      @(negedge clk);
      clear = 1'b1;
      ls_req = 1'b0;
      if_addr = 32'h0000_5000;
      if_req = 1'b1;
      @(negedge clk);
      check("clr_kill_state", 64'(dbg_state), 64'd0);
      man_rdata = 64'h5555_6666_7777_8888;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      check("clr_no_ls_done", 64'(ls_done), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("clr_no_grant", 64'(mc_sig), 64'd0);
      end
      check("clr_state_idle", 64'(dbg_state), 64'd0);
      mc_auto = 1'b1;
      mc_lat = 2;
      push_mc(1'b0, 4'd8, 32'h0000_5000, 32'd0);
      rsp_q.push_back(64'hfeed_face_0000_0001);
      exp_if_q.push_back(64'hfeed_face_0000_0001);
      clear = 1'b0;
      wait_out(1, "clr_fetch");
      if_req = 1'b0;
      repeat (2) @(negedge clk);

      // store survives clear held from ISSUE through RESP
      mc_lat = 3;
      push_mc(1'b1, 4'd4, 32'h0000_0080, 32'hdead_beef);
      rsp_q.push_back(64'd0);
      exp_ls_q.push_back({1'b0, 32'd0});
      ls_wr = 1'b1;
      ls_len = 3'd4;
      ls_addr = 32'h0000_0080;
      ls_wdata = 32'hdead_beef;
      ls_req = 1'b1;
      wait_out(0, "store_issue");
      clear = 1'b1;
      wait_out(2, "store_done");
      ls_req = 1'b0;
      ls_wr = 1'b0;
      clear = 1'b0;
      repeat (2) @(negedge clk);

      // rdy low in WAIT with mc_done held
      mc_auto = 1'b0;
      push_mc(1'b0, 4'd4, 32'h0000_00c0, 32'd0);
      exp_ls_q.push_back({1'b1, 32'hcafe_f00d});
      ls_len = 3'd4;
      ls_addr = 32'h0000_00c0;
      ls_req = 1'b1;
      wait_out(0, "rdy_issue");
      @(negedge clk);
      rdy = 1'b0;
      man_rdata = 64'h1234_5678_cafe_f00d;
      man_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rdy_hold_state", 64'(dbg_state), 64'd2);
         check("rdy_hold_no_done", 64'(ls_done), 64'd0);
      end
      rdy = 1'b1;
      @(negedge clk);
      check("rdy_resume_done", 64'(ls_done), 64'd1);
      man_done = 1'b0;
      ls_req = 1'b0;
      repeat (2) @(negedge clk);

      // asynchronous reset mid-WAIT
      push_mc(1'b0, 4'd4, 32'h0000_00d0, 32'd0);
      ls_addr = 32'h0000_00d0;
      ls_req = 1'b1;
      wait_out(0, "rst_issue");
      @(negedge clk);
      rst_n = 1'b0;
      ls_req = 1'b0;
      #1;
      check("arst_state", 64'(dbg_state), 64'd0);
      check("arst_mc_addr", 64'(mc_addr), 64'd0);
      check("arst_mc_wdata", 64'(mc_wdata), 64'd0);
      check("arst_mc_len", 64'(mc_len), 64'd0);
      check("arst_if_data", if_data, 64'd0);
      check("arst_ls_rdata", 64'(ls_rdata), 64'd0);
      check("arst_ls_done", 64'(ls_done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_idle", 64'(dbg_state), 64'd0);
      check("post_rst_no_sig", 64'(mc_sig), 64'd0);

      repeat (3) @(negedge clk);
      check("exp_mc_left", 64'(exp_mc_q.size()), 64'd0);
      check("exp_if_left", 64'(exp_if_q.size()), 64'd0);
      check("exp_ls_left", 64'(exp_ls_q.size()), 64'd0);
      check("rsp_left", 64'(rsp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
